fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the hazard unit and consumes its pcen, if_id_en and if_id_flush outputs.
- Owns the PC register, accepts branch/jump redirects resolved in MEM, and stops fetching on HALT.
- Contains the IF/ID pipeline register that feeds decode.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, absorbs MEM-resolved redirects
// (holding them while the PC is stalled), stops fetching on HALT, and
// drives the IF/ID pipeline register toward decode.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP = 6'b111111
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pcen,
   input  logic        if_id_en,
   input  logic        if_id_flush,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic        fetch_halted
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc_plus4;
   logic        pend_valid;
   logic [31:0] pend_pc;
   logic        redirect_now;
   logic [31:0] target;
   logic        halt_det;

   // A live redirect beats a stored one; the stored one covers stalls.
   assign redirect_now = redir_valid | pend_valid;
   assign target       = redir_valid ? redir_pc : pend_pc;
   assign pc_plus4     = pc + 32'd4;

   // HALT only counts when the word is actually entering IF/ID on the
   // correct path; a same-cycle redirect marks it wrong-path.
   assign halt_det = (state == RUN) && ihit && (imemload[31:26] == HALT_OP)
                     && if_id_en && !if_id_flush && !redirect_now;

   assign imemaddr     = pc;
   assign imemREN      = (state == RUN);
   assign fetch_halted = (state == HALTED);

   // Next PC / next fetch state; redirect leaves HALTED, HALT freezes the PC.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (halt_det)
         state_nxt = HALTED;
      if (pcen) begin
         if (redirect_now) begin
            pc_nxt    = target;
            state_nxt = RUN;
         end else if (state == RUN && !halt_det) begin
            pc_nxt = pc_plus4;
         end
      end
   end

   // PC and fetch state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= RUN;
         pc    <= PC_INIT;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Pending redirect: captured while stalled, dropped once the PC moves.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_valid <= 1'b0;
         pend_pc    <= 32'd0;
      end else if (pcen) begin
         pend_valid <= 1'b0;
      end else if (redir_valid) begin
         pend_valid <= 1'b1;
         pend_pc    <= redir_pc;
      end
   end

   // IF/ID register: flush > hold > wrong-path bubble > load > bubble.
   always_ff @(posedge CLK) begin
      if (RST || if_id_flush) begin
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
         if_npc   <= 32'd0;
         if_valid <= 1'b0;
      end else if (if_id_en) begin
         if (!redirect_now && ihit && state == RUN) begin
            if_instr <= imemload;
            if_pc    <= pc;
            if_npc   <= pc_plus4;
            if_valid <= 1'b1;
         end else begin
            if_instr <= 32'd0;
            if_pc    <= 32'd0;
            if_npc   <= 32'd0;
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pcen = 1'b0, if_id_en = 1'b0, if_id_flush = 1'b0, ihit = 1'b0;
   logic [31:0] imemload = 32'd0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = 32'd0;

   logic        imemREN, if_valid, fetch_halted;
   logic [31:0] imemaddr, if_instr, if_pc, if_npc;

   logic        w_ren, w_valid, w_halted;
   logic [31:0] w_addr, w_instr, w_pc, w_npc;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_instr, m_ipc, m_inpc;
   logic        m_ivalid;

   always #5 clk = ~clk;

   fetch_stage dut (
      .CLK(clk), .RST(rst), .pcen(pcen), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .ihit(ihit), .imemload(imemload),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .imemREN(imemREN), .imemaddr(imemaddr), .if_instr(if_instr),
      .if_pc(if_pc), .if_npc(if_npc), .if_valid(if_valid),
      .fetch_halted(fetch_halted)
   );

   fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
      .CLK(clk), .RST(rst), .pcen(pcen), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .ihit(ihit), .imemload(imemload),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .imemREN(w_ren), .imemaddr(w_addr), .if_instr(w_instr),
      .if_pc(w_pc), .if_npc(w_npc), .if_valid(w_valid),
      .fetch_halted(w_halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("imemaddr",     imemaddr,            m_pc);
      chk("imemREN",      {31'd0, imemREN},    {31'd0, !m_halted});
      chk("fetch_halted", {31'd0, fetch_halted}, {31'd0, m_halted});
      chk("if_instr",     if_instr,            m_instr);
      chk("if_pc",        if_pc,               m_ipc);
      chk("if_npc",       if_npc,              m_inpc);
      chk("if_valid",     {31'd0, if_valid},   {31'd0, m_ivalid});
   endtask

   // One clock: apply inputs, advance the model by the stage's rules, check.
   task automatic step(input logic pe, input logic ie, input logic fl, input logic ih,
                       input logic [31:0] ld, input logic rv, input logic [31:0] rp,
                       input logic r);
      logic        redirect, halt;
      logic [31:0] tgt;
      pcen = pe; if_id_en = ie; if_id_flush = fl; ihit = ih;
      imemload = ld; redir_valid = rv; redir_pc = rp; rst = r;
      if (r) begin
         m_pc = 32'd0; m_halted = 1'b0; m_pend = 1'b0; m_pend_pc = 32'd0;
         m_instr = 32'd0; m_ipc = 32'd0; m_inpc = 32'd0; m_ivalid = 1'b0;
      end else begin
         redirect = rv || m_pend;
         tgt      = rv ? rp : m_pend_pc;
         halt     = !m_halted && ih && (ld[31:26] == 6'h3F) && ie && !fl && !redirect;
         // decode register
         if (fl || (ie && (redirect || !ih || m_halted))) begin
            m_instr = 32'd0; m_ipc = 32'd0; m_inpc = 32'd0; m_ivalid = 1'b0;
         end else if (ie) begin
            m_instr = ld; m_ipc = m_pc; m_inpc = m_pc + 32'd4; m_ivalid = 1'b1;
         end
         // program counter and halt
         if (halt) m_halted = 1'b1;
         if (pe) begin
            if (redirect) begin
               m_pc = tgt; m_halted = 1'b0;
            end else if (!m_halted) begin
               m_pc = m_pc + 32'd4;
            end
         end
         // pending redirect
         if (pe) m_pend = 1'b0;
         else if (rv) begin m_pend = 1'b1; m_pend_pc = rp; end
      end
      @(posedge clk);
      #1;
      chk_all();
   endtask

   initial begin
      logic [31:0] ld;
      @(posedge clk); #1;

      // reset state
      step(0, 0, 0, 0, 32'd0, 0, 32'd0, 1);
      chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);

      // sequential fetch
      step(1, 1, 0, 1, 32'h2001_0005, 0, 32'd0, 0);
      step(1, 1, 0, 1, 32'h2002_0007, 0, 32'd0, 0);
      step(1, 1, 0, 1, 32'h0022_1820, 0, 32'd0, 0);
      chk("seq_addr", imemaddr, 32'd12);
      chk("seq_if_pc", if_pc, 32'd8);
      chk("seq_if_npc", if_npc, 32'd12);
      chk("seq_if_instr", if_instr, 32'h0022_1820);

      // stall with pending redirect, consumed two cycles later
      step(0, 1, 0, 1, 32'h0000_0001, 1, 32'h100, 0);
      chk("stall_hold", imemaddr, 32'd12);
      step(0, 1, 0, 1, 32'h0000_0002, 0, 32'd0, 0);
      chk("stall_hold2", imemaddr, 32'd12);
      step(1, 1, 0, 1, 32'h0000_0003, 0, 32'd0, 0);
      chk("pend_redir_addr", imemaddr, 32'h100);
      chk("pend_bubble", {31'd0, if_valid}, 32'd0);
      step(1, 1, 0, 1, 32'h0000_0004, 0, 32'd0, 0);
      chk("pend_cleared", imemaddr, 32'h104);

      // flush beats enable
      step(1, 1, 1, 1, 32'h1234_5678, 0, 32'd0, 0);
      chk("flush_instr", if_instr, 32'd0);

      // HALT at 0x10
      step(1, 1, 0, 0, 32'd0, 1, 32'h10, 0);
      step(1, 1, 0, 1, 32'hFC00_0000, 0, 32'd0, 0);
      chk("halt_instr", if_instr, 32'hFC00_0000);
      chk("halt_if_pc", if_pc, 32'h10);
      chk("halted", {31'd0, fetch_halted}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 1, 32'h0000_1111 + i, 0, 32'd0, 0);
         chk("halt_pc_frozen", imemaddr, 32'h10);
      end

      // redirect while halted resumes fetch
      step(1, 1, 0, 1, 32'd0, 1, 32'h200, 0);
      chk("unhalt", {31'd0, fetch_halted}, 32'd0);
      chk("unhalt_addr", imemaddr, 32'h200);

      // HALT squashed by same-cycle redirect
      step(1, 1, 0, 1, 32'hFC00_0000, 1, 32'h40, 0);
      chk("squash_halted", {31'd0, fetch_halted}, 32'd0);
      chk("squash_addr", imemaddr, 32'h40);
      chk("squash_bubble", {31'd0, if_valid}, 32'd0);

      // reset while halted with a pending redirect
      step(1, 1, 0, 1, 32'hFC00_0000, 0, 32'd0, 0);
      step(0, 1, 0, 1, 32'd0, 1, 32'h80, 0);
      chk("pre_rst_halted", {31'd0, fetch_halted}, 32'd1);
      step(1, 1, 0, 1, 32'h5555_5555, 1, 32'h80, 1);
      chk("rst_addr", imemaddr, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);

      // PC wrap on the high-PC_INIT instance
      chk("wrap_pre", w_addr, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 32'd0, 0, 32'd0, 0);
      chk("wrap_addr", w_addr, 32'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         ld = $urandom;
         if ($urandom_range(0, 7) == 0) ld[31:26] = 6'h3F;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0, ld,
              $urandom_range(0, 5) == 0, {$urandom} & 32'hFFFF_FFFC,
              $urandom_range(0, 63) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
